// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the instruction-fetch / PC sequencer.
//   - sequencer state encoding
//   - opcode constants recognised by the sequencer itself
//   - instruction field positions and an opcode extraction helper
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } pc_seq_state_e;

  localparam logic [5:0] OP_BEQ  = 6'b001001;
  localparam logic [5:0] OP_JUMP = 6'b010111;
  localparam logic [5:0] OP_NOP  = 6'b011000;
  localparam logic [5:0] OP_STOP = 6'b011001;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int OFFSET_HI = 15;
  localparam int OFFSET_LO = 0;

  function automatic logic [5:0] get_opcode(input logic [31:0] word);
    return word[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory fetch channel.
//   imem_req   : fetch request, held until imem_valid
//   imem_addr  : fetch address (PC_W bits), stable while imem_req is high
//   imem_valid : read data valid
//   imem_rdata : 32-bit instruction word
// master = sequencer side, slave = instruction memory side.
interface pc_sequencer_if #(
  parameter int PC_W = 10
) ();

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection for the sequencer.
// Ports:
//   pc        in  current PC
//   instr     in  instruction being executed
//   cu_Jump, cu_Branch, cu_hlt in  decoded control from the control unit
//   alu_zero  in  ALU zero flag (BEQ compare)
//   pc_next   out PC to load after this instruction
//   halt_req  out this instruction stops the core
// All arithmetic wraps modulo 2^PC_W.
module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     instr,
  input  logic            cu_Jump,
  input  logic            cu_Branch,
  input  logic            cu_hlt,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc_next,
  output logic            halt_req
);

  logic [5:0]        op;
  logic signed [15:0] offset;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_br;
  logic              unused_instr;

  assign op     = get_opcode(instr);
  assign offset = $signed(instr[OFFSET_HI:OFFSET_LO]);
  assign pc_inc = pc + PC_W'(1);
  // Sign-extend through 32 bits first so PC_W > 16 still gets a proper
  // extension, then truncate: the wrap falls out of the PC_W-bit add.
  assign pc_br  = pc + PC_W'(1) + PC_W'(32'(offset));

  // Only the opcode, offset and low PC_W bits are consumed.
  assign unused_instr = ^instr;

  // NOP is decoded before any cu_* input because the control unit leaves
  // them undefined for that opcode.
  always_comb begin
    halt_req = 1'b0;
    pc_next  = pc_inc;
    if (op == OP_STOP) begin
      halt_req = 1'b1;
      pc_next  = pc;
    end else if (op == OP_NOP) begin
      pc_next  = pc_inc;
    end else if (cu_hlt) begin
      halt_req = 1'b1;
      pc_next  = pc;
    end else if (cu_Jump) begin
      pc_next  = instr[PC_W-1:0];
    end else if (cu_Branch && alu_zero) begin
      pc_next  = pc_br;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch and program-counter sequencer.
// Fetches a word at pc, issues it to the control unit (opcode/instr_valid),
// waits for exec_done, then resolves halt / jump / branch / sequential.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem                pc_sequencer_if.master fetch channel
//   instr, opcode       latched instruction and its opcode field
//   instr_valid         one-cycle pulse per issued instruction
//   exec_done           execute finished; control inputs sampled with it
//   cu_Jump, cu_Branch, cu_hlt, alu_zero  control-unit / ALU decisions
//   pc                  current PC
//   halted              core stopped (only rst_n leaves this)
//   retired_cnt         retired-instruction count
// Build option: define PC_SEQ_RETIRE_CNT_EN to build the retired-instruction
// counter; otherwise retired_cnt is tied to zero.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.master  imem,
  output logic [31:0]     instr,
  output logic [5:0]      opcode,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic            cu_Jump,
  input  logic            cu_Branch,
  input  logic            cu_hlt,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [31:0]     retired_cnt
);

  pc_seq_state_e   state;
  pc_seq_state_e   state_nxt;
  logic [PC_W-1:0] pc_calc;
  logic            halt_req;
  logic            exec_acc;

  assign exec_acc = (state == ST_EXEC) && exec_done;

  pc_next_calc #(
    .PC_W (PC_W)
  ) u_pc_next_calc (
    .pc        (pc),
    .instr     (instr),
    .cu_Jump   (cu_Jump),
    .cu_Branch (cu_Branch),
    .cu_hlt    (cu_hlt),
    .alu_zero  (alu_zero),
    .pc_next   (pc_calc),
    .halt_req  (halt_req)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (imem.imem_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_EXEC;
      ST_EXEC:  if (exec_done) state_nxt = halt_req ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe rather than lagging it by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      instr         <= '0;
      opcode        <= '0;
      imem.imem_req <= 1'b0;
      instr_valid   <= 1'b0;
      halted        <= 1'b0;
    end else begin
      state         <= state_nxt;
      imem.imem_req <= (state_nxt == ST_FETCH);
      instr_valid   <= (state_nxt == ST_ISSUE);
      halted        <= (state_nxt == ST_HALT);
      if ((state == ST_FETCH) && imem.imem_valid) begin
        instr  <= imem.imem_rdata;
        opcode <= get_opcode(imem.imem_rdata);
      end
      if (exec_acc && !halt_req) begin
        pc <= pc_calc;
      end
    end
  end

  assign imem.imem_addr = pc;

`ifdef PC_SEQ_RETIRE_CNT_EN
  // Counts the halting instruction too; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (exec_acc) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Acts as instruction memory and control unit, drives directed and random
// instructions, and compares against a transaction-level PC model.
`timescale 1ns/1ps
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int PC_W   = 10;
  localparam int PC_MOD = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     instr;
  logic [5:0]      opcode;
  logic            instr_valid;
  logic            exec_done = 1'b0;
  logic            cu_Jump = 1'b0;
  logic            cu_Branch = 1'b0;
  logic            cu_hlt = 1'b0;
  logic            alu_zero = 1'b0;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic [31:0]     retired_cnt;

  pc_sequencer_if #(.PC_W(PC_W)) imem ();

  pc_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .cu_Jump     (cu_Jump),
    .cu_Branch   (cu_Branch),
    .cu_hlt      (cu_hlt),
    .alu_zero    (alu_zero),
    .pc          (pc),
    .halted      (halted),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned iv_cyc = 0;
  int unsigned prev_iv = 0;
  int unsigned m_pc = 0;
  int unsigned m_retired = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ret();
`ifdef PC_SEQ_RETIRE_CNT_EN
    return m_retired;
`else
    return 32'd0;
`endif
  endfunction

  // Architectural rule for one executed instruction.
  function automatic void model_step(input logic [31:0] w, input logic j, b, h, z,
                                     output bit halt, output int unsigned nxt);
    logic [5:0] op;
    int         t;
    op   = w[31:26];
    halt = (op == OP_STOP) || (op != OP_NOP && h === 1'b1);
    nxt  = m_pc;
    if (halt) nxt = m_pc;
    else if (op == OP_NOP) nxt = (m_pc + 1) % PC_MOD;
    else if (j === 1'b1) nxt = w[PC_W-1:0];
    else if (b === 1'b1 && z === 1'b1) begin
      t   = int'(m_pc) + 1 + int'($signed(w[15:0]));
      nxt = int'(t & (PC_MOD - 1));
    end else nxt = (m_pc + 1) % PC_MOD;
  endfunction

  function automatic logic [31:0] rand_plain_word();
    logic [5:0] op;
    do op = 6'($urandom);
    while (op == OP_STOP || op == OP_NOP || op == OP_BEQ || op == OP_JUMP);
    return {op, 26'($urandom)};
  endfunction

  // One instruction from FETCH through EXEC; leaves the bench at the
  // falling edge after the resolving exec_done.
  task automatic run_instr(input logic [31:0] word, input logic j, b, h, z,
                           input int fwait, input int ewait, input bit noise);
    bit          exp_halt;
    int unsigned exp_pc;
    for (int i = 0; i < 8 && imem.imem_req !== 1'b1; i++) @(negedge clk);
    check("fetch_req", 32'(imem.imem_req), 32'd1);
    check("fetch_addr", 32'(imem.imem_addr), m_pc);
    for (int i = 0; i < fwait; i++) begin
      imem.imem_valid = 1'b0;
      imem.imem_rdata = $urandom;
      if (noise) begin
        exec_done = 1'b1; cu_Jump = 1'b1; cu_hlt = 1'b1;
      end
      @(negedge clk);
      exec_done = 1'b0; cu_Jump = 1'b0; cu_hlt = 1'b0;
      check("wait_req", 32'(imem.imem_req), 32'd1);
      check("wait_addr", 32'(imem.imem_addr), m_pc);
    end
    imem.imem_valid = 1'b1;
    imem.imem_rdata = word;
    @(negedge clk);
    prev_iv = iv_cyc;
    iv_cyc  = cyc;
    check("issue_iv", 32'(instr_valid), 32'd1);
    check("issue_instr", instr, word);
    check("issue_opcode", 32'(opcode), 32'(word[31:26]));
    if (noise) begin
      imem.imem_valid = 1'b1; imem.imem_rdata = ~word;
    end else imem.imem_valid = 1'b0;
    @(negedge clk);
    check("exec_iv", 32'(instr_valid), 32'd0);
    for (int i = 0; i < ewait; i++) @(negedge clk);
    cu_Jump = j; cu_Branch = b; cu_hlt = h; alu_zero = z; exec_done = 1'b1;
    model_step(word, j, b, h, z, exp_halt, exp_pc);
    @(negedge clk);
    exec_done = 1'b0; cu_Jump = 1'b0; cu_Branch = 1'b0; cu_hlt = 1'b0; alu_zero = 1'b0;
    imem.imem_valid = 1'b0;
    m_retired++;
    m_pc = exp_pc;
    check("next_pc", 32'(pc), m_pc);
    check("next_halted", 32'(halted), 32'(exp_halt));
    check("next_req", 32'(imem.imem_req), 32'(!exp_halt));
    check("instr_hold", instr, word);
    check("retired", retired_cnt, exp_ret());
  endtask

  task automatic hold_halt();
    for (int i = 0; i < 20; i++) begin
      exec_done = 1'($urandom_range(0, 1));
      cu_Jump   = 1'($urandom_range(0, 1));
      imem.imem_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_req", 32'(imem.imem_req), 32'd0);
      check("halt_pc", 32'(pc), m_pc);
      check("halt_ret", retired_cnt, exp_ret());
    end
    exec_done = 1'b0; cu_Jump = 1'b0; imem.imem_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 32'(imem.imem_req), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_iv"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_opcode"}, 32'(opcode), 32'd0);
    check({tag, "_ret"}, retired_cnt, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst");
    m_pc = 0;
    m_retired = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] w;
  logic        rj, rb, rh, rz;
  logic [31:0] ret5;

  initial begin
    imem.imem_valid = 1'b0;
    imem.imem_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_values("init");
    rst_n = 1'b1;

    // Minimum-latency sequential run, jump to top of space, wrap to 0.
    run_instr(rand_plain_word(), 0, 0, 0, 0, 0, 0, 0);
    run_instr(rand_plain_word(), 0, 0, 0, 0, 0, 0, 0);
    check("iv_gap_a", iv_cyc - prev_iv, 32'd3);
    run_instr({OP_JUMP, 16'h0, 10'h3FF}, 1, 0, 0, 0, 0, 0, 0);
    check("iv_gap_b", iv_cyc - prev_iv, 32'd3);
    check("jump_pc", 32'(pc), 32'd1023);
    run_instr(rand_plain_word(), 0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", 32'(pc), 32'd0);

    // BEQ at pc 5 with offset -3, taken then not taken.
    for (int i = 0; i < 5; i++) run_instr(rand_plain_word(), 0, 0, 0, 0, 1, 1, 1);
    run_instr({OP_BEQ, 10'h0, 16'hFFFD}, 0, 1, 0, 1, 0, 0, 0);
    check("beq_taken", 32'(pc), 32'd3);
    run_instr(rand_plain_word(), 0, 0, 0, 0, 0, 0, 0);
    run_instr(rand_plain_word(), 0, 0, 0, 0, 0, 0, 0);
    run_instr({OP_BEQ, 10'h0, 16'hFFFD}, 0, 1, 0, 0, 0, 0, 0);
    check("beq_not_taken", 32'(pc), 32'd6);
    run_instr({OP_NOP, 26'h0}, 1'bx, 1'bx, 1'b0, 1'bx, 0, 0, 0);
    check("nop_pc", 32'(pc), 32'd7);

    // Random mix with fetch/exec wait states and ignored-input noise.
    for (int n = 0; n < 120; n++) begin
      rj = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rz = 1'($urandom_range(0, 1));
      rh = 1'b0;
      case ($urandom_range(0, 3))
        0: w = rand_plain_word();
        1: begin w = {OP_BEQ, 10'($urandom), 16'($urandom)}; rj = 1'b0; rb = 1'b1; end
        2: begin w = {OP_JUMP, 26'($urandom)}; rj = 1'b1; end
        default: begin w = {OP_NOP, 26'($urandom)}; rh = 1'($urandom_range(0, 1)); end
      endcase
      run_instr(w, rj, rb, rh, rz, $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)));
    end

    // Halt via cu_hlt, hold, reset.
    run_instr(rand_plain_word(), 0, 0, 1, 0, 0, 0, 0);
    hold_halt();
    apply_reset();

    // Four instructions plus stop from reset.
    for (int i = 0; i < 4; i++) run_instr(rand_plain_word(), 0, 0, 0, 0, 0, 0, 0);
    run_instr({OP_STOP, 26'($urandom)}, 0, 0, 0, 0, 0, 0, 0);
`ifdef PC_SEQ_RETIRE_CNT_EN
    ret5 = 32'd5;
`else
    ret5 = 32'd0;
`endif
    check("retired_after_stop", retired_cnt, ret5);
    check("stop_pc", 32'(pc), 32'd4);
    hold_halt();
    apply_reset();
    run_instr(rand_plain_word(), 0, 0, 0, 0, 0, 0, 0);
    check("resume_pc", 32'(pc), 32'd1);

    // Reset mid-fetch with imem_valid withheld.
    imem.imem_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_req", 32'(imem.imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("fetch_rst");
    m_pc = 0;
    m_retired = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(rand_plain_word(), 0, 0, 0, 0, 1, 0, 0);
    check("after_fetch_rst_pc", 32'(pc), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch and program-counter sequencer at the other end of the `controlUnity` interface. It fetches 32-bit instruction words from instruction memory and presents the 6-bit opcode to the control unit. It then consumes the resulting Jump/Branch/hlt decisions and the ALU zero flag to compute the next PC. It also owns the halt state of the core.

## Interface
- `PC_W`, 10: PC and instruction-memory address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request; held high until `imem_valid`.
- `imem_addr`  out  PC_W  fetch address, equal to `pc`; stable while `imem_req` is high.
- `imem_valid`  in  1  fetch data valid; ignored unless in FETCH.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  latched instruction.
- `opcode`  out  6  `instr[31:26]`, drives the control-unit opcode input.
- `instr_valid`  out  1  one-cycle pulse when a new instruction is issued.
- `exec_done`  in  1  execute stage finished; control inputs are sampled on it.
- `cu_Jump`, `cu_Branch`, `cu_hlt`  in  1 each  decoded control from the control unit.
- `alu_zero`  in  1  ALU result zero (BEQ compare).
- `pc`  out  PC_W  current PC.
- `halted`  out  1  core stopped.
- `retired_cnt`  out  32  retired-instruction count (see Configuration).

## Operation
- States: IDLE, FETCH, ISSUE, EXEC, HALT.
- Reset values:
  - State is IDLE.
  - `pc` = RESET_PC.
  - `instr` = 0, `opcode` = 0.
  - `imem_req`, `instr_valid`, `halted` = 0.
  - `retired_cnt` = 0.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH:
  - `imem_req` = 1.
  - On `imem_valid`: latch `imem_rdata` into `instr`, go to ISSUE.
- ISSUE:
  - `instr_valid` = 1 for exactly this cycle.
  - Go to EXEC.
- EXEC: wait for `exec_done`. On it, resolve in priority order:
  - Opcode 6'b011001 (stop) or `cu_hlt`: go to HALT, `pc` unchanged.
  - Opcode 6'b011000 (NOP): `pc`+1, and all `cu_*` inputs are ignored because they are X for this opcode.
  - `cu_Jump`: `pc` = `instr[PC_W-1:0]`.
  - `cu_Branch` && `alu_zero`: `pc` = `pc` + 1 + sign-extended `instr[15:0]`, truncated to PC_W.
  - Otherwise: `pc`+1.
  - Then go to FETCH, except in the halt case.
- HALT:
  - `halted` = 1.
  - `imem_req` = 0.
  - The state is left only by `rst_n`.
- All PC arithmetic wraps modulo 2^PC_W: `pc` = 2^PC_W-1 followed by +1 gives 0.
- `exec_done` is ignored outside EXEC. `imem_valid` is ignored outside FETCH.
- `rst_n` low in any state returns immediately to reset values, including mid-fetch; any outstanding fetch is abandoned.

## Timing
- All outputs are registered. `opcode` and `instr` change on the clock edge that enters ISSUE.
- `imem_valid` in the first FETCH cycle gives the minimum cost of 3 cycles per instruction: FETCH, ISSUE, and EXEC with `exec_done` in its first cycle.
- Fetch wait states extend FETCH one cycle each. `imem_addr` holds throughout.
- The new `pc` is visible the cycle after `exec_done`, coincident with `imem_req` rising for the next fetch.
- `halted` rises the cycle after the `exec_done` that resolves the halt.

## Configuration
- `PC_SEQ_RETIRE_CNT_EN` defined:
  - `retired_cnt` increments by 1 on each `exec_done` accepted in EXEC, including the halting instruction.
  - It wraps at 2^32.
- Not defined: `retired_cnt` is tied to 0 and no counter logic is built.

## Structure
- Package `pc_seq_pkg` holds:
  - State enum.
  - Opcode constants OP_BEQ = 6'b001001, OP_JUMP = 6'b010111, OP_NOP = 6'b011000, OP_STOP = 6'b011001.
  - Field positions: opcode [31:26], offset [15:0].
- One sub-module, `pc_next_calc`: combinational next-PC selection and arithmetic. The FSM and registers stay in `pc_sequencer`.

## Test plan
- Reset with RESET_PC = 0, `imem_valid` tied high, exec_done one cycle after each `instr_valid`, all `cu_*` = 0:
  - `pc` sequences 0, 1, 2.
  - `instr_valid` pulses every 3 cycles.
- BEQ at `pc` = 5 with offset 16'hFFFD, `cu_Branch` = 1, `alu_zero` = 1 -> next `pc` = 3. Same instruction with `alu_zero` = 0 -> next `pc` = 6.
- Jump with `instr[9:0]` = 10'h3FF at `pc` = 2 -> `pc` = 1023. Next sequential instruction -> `pc` = 0 (wrap).
- NOP with `cu_Jump` and `cu_Branch` driven X -> `pc`+1, no X on `pc`.
- Stop opcode, then:
  - `halted` = 1, `imem_req` stays 0 for 20 cycles.
  - Subsequent `exec_done` pulses ignored.
  - `rst_n` pulse -> `pc` = 0 and fetch resumes.
- `rst_n` asserted in FETCH with `imem_valid` withheld -> `imem_req` = 0 immediately. With the macro defined, a run of 4 instructions plus stop gives `retired_cnt` = 5.
